divider_16by8bits: RTL and testbench

DIVIDER_16BY8BITS -- requirements
Module: divider_16by8bits

---
 rtl/divider_16by8bits.sv | 122 ++++++++++++
 tb/tb_divider_16by8bits.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/divider_16by8bits.sv
// Sequential restoring divider: 2N-bit unsigned dividend by N-bit divisor,
// one quotient bit per cycle, with up-front overflow / divide-by-zero detection.
module divider_16by8bits #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           st,
    input  logic [2*N-1:0] dvd,
    input  logic [N-1:0]   dvs,
    output logic [N-1:0]   quo,
    output logic [N-1:0]   rem,
    output logic           done,
    output logic           ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N:0]    acc_q, acc_d;
    logic [N-1:0]    dvs_q, dvs_d;
    logic [N-1:0]    quo_q, quo_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic [2*N:0]    shifted;
    logic [N:0]      upper;
    logic [N:0]      diff;
    logic            fits;
    logic [2*N:0]    step;

    // A set acc_q[2N] would be shifted out; its weight alone exceeds any divisor.
    always_comb begin
        shifted = {acc_q[2*N-1:0], 1'b0};
        upper   = shifted[2*N:N];
        diff    = upper - {1'b0, dvs_q};
        fits    = acc_q[2*N] || (upper >= {1'b0, dvs_q});
        step    = fits ? {diff, shifted[N-1:1], 1'b1} : shifted;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                ovf_d  = 1'b0;
                if (st) begin
                    acc_d = {1'b0, dvd};
                    dvs_d = dvs;
                    cnt_d = '0;
                    if (dvs == '0 || dvd[2*N-1:N] >= dvs) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = '0;
                        done_d  = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    quo_d   = step[N-1:0];
                    rem_d   = step[2*N-1:N];
                    done_d  = 1'b1;
                    ovf_d   = 1'b0;
                end
            end
            DONE: begin
                if (!st) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_divider_16by8bits.sv
// Scoreboard bench for divider_16by8bits: directed operands with hand-computed
// quotient/remainder/overflow and exact done latency.
module tb_divider_16by8bits;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  quo;
    logic [7:0]  rem;
    logic        done;
    logic        ovf;

    divider_16by8bits #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .st  (st),
        .dvd (dvd),
        .dvs (dvs),
        .quo (quo),
        .rem (rem),
        .done(done),
        .ovf (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       o;
        int         t;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every rising done is matched against the oldest expectation.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no result", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("vec %s: quo=0x%02h rem=0x%02h ovf=%0b cycle=%0d", e.name, quo, rem, ovf, cyc);
                check({e.name, "_quo"},   quo, e.q);
                check({e.name, "_rem"},   rem, e.r);
                check({e.name, "_ovf"},   ovf, e.o);
                check({e.name, "_cycle"}, cyc, e.t);
            end
        end
        done_prev <= done;
    end

    task automatic start_op(input logic [15:0] a, input logic [7:0] b,
                            input logic [7:0] q, input logic [7:0] r,
                            input logic o, input int lat, input string name);
        exp_t e;
        @(negedge clk);
        dvd = a;
        dvs = b;
        st  = 1'b1;
        @(posedge clk);
        #1;
        e.q = q; e.r = r; e.o = o; e.t = cyc + lat; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done within 30 cycles, expected done", name);
            sb.delete();
        end
    endtask

    // done must hold while st stays high, then clear one edge after st drops.
    task automatic finish_op(input string name);
        @(negedge clk);
        check({name, "_hold"}, done, 1'b1);
        st = 1'b0;
        @(negedge clk);
        check({name, "_drop_done"}, done, 1'b0);
        check({name, "_drop_ovf"},  ovf,  1'b0);
    endtask

    initial begin
        rst = 1'b0;
        st  = 1'b0;
        dvd = '0;
        dvs = '0;
        #1;
        check("reset_quo",  quo,  8'h00);
        check("reset_rem",  rem,  8'h00);
        check("reset_done", done, 1'b0);
        check("reset_ovf",  ovf,  1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_done", done, 1'b0);

        start_op(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 8, "d1000_7");
        repeat (3) @(negedge clk);
        check("run_quo_held", quo, 8'h00);
        wait_sb("d1000_7");
        finish_op("d1000_7");

        start_op(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 8, "dFEFF_FF");
        wait_sb("dFEFF_FF");
        finish_op("dFEFF_FF");

        start_op(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 8, "d00FF_01");
        wait_sb("d00FF_01");
        finish_op("d00FF_01");

        start_op(16'hABCD, 8'h00, 8'hFF, 8'h00, 1'b1, 0, "div_zero");
        wait_sb("div_zero");
        finish_op("div_zero");

        start_op(16'h0500, 8'h05, 8'hFF, 8'h00, 1'b1, 0, "ovf_0500_05");
        wait_sb("ovf_0500_05");
        finish_op("ovf_0500_05");

        start_op(16'h0100, 8'h01, 8'hFF, 8'h00, 1'b1, 0, "ovf_0100_01");
        wait_sb("ovf_0100_01");
        finish_op("ovf_0100_01");

        start_op(16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 8, "d0000_05");
        wait_sb("d0000_05");
        finish_op("d0000_05");

        // Operands change mid-run; result must follow the latched ones.
        start_op(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 8, "latched_ops");
        repeat (2) @(negedge clk);
        dvd = 16'h1234;
        dvs = 8'h99;
        @(negedge clk);
        check("latched_quo_held", quo, 8'h00);
        wait_sb("latched_ops");
        finish_op("latched_ops");

        start_op(16'h1234, 8'h99, 8'h1E, 8'h46, 1'b0, 8, "d1234_99");
        wait_sb("d1234_99");
        finish_op("d1234_99");

        // Reset at E0+4 abandons the run and clears outputs immediately.
        @(negedge clk);
        dvd = 16'h03E8;
        dvs = 8'h07;
        st  = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrun_rst_done", done, 1'b0);
        check("midrun_rst_quo",  quo,  8'h00);
        check("midrun_rst_rem",  rem,  8'h00);
        st = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("after_rst_idle_done", done, 1'b0);

        start_op(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 8, "restart_1000_7");
        wait_sb("restart_1000_7");
        finish_op("restart_1000_7");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
